// File: rtl/ex_id_hazard_fwd.sv
// Hazard unit for a 5-stage pipe: tracks MEM/WB destinations, forwards results to decode,
// and sequences stalls, bubbles and branch flushes.
module ex_id_hazard_fwd #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [XLEN-1:0] id_rs1_rdata,
    input  logic [XLEN-1:0] id_rs2_rdata,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_busy,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] id_rs1_fwd,
    output logic [XLEN-1:0] id_rs2_fwd,
    output logic            stall_o,
    output logic            hold_ex_o,
    output logic            bubble_o,
    output logic            flush_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_LDSTALL = 2'd2;
    localparam logic [1:0] ST_FLUSH   = 2'd3;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
        logic [XLEN-1:0]  data;
    } hist_t;

    hist_t            m_q, w_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble_q;
    logic             wb_done_q;
    logic             branch;
    logic             load_use;
    logic             ex_fwd_ok;
    logic             m_fwd_ok;
    logic             w_fwd_ok;
    logic [XLEN-1:0]  m_val;

    // Hazard qualifiers
    always_comb begin
        branch   = ex_valid & ex_branch_taken & ~ex_busy;
        load_use = id_valid & ex_valid & ex_is_load & ex_we & (ex_rd != '0) &
                   ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    end

    // Next state and control outputs; reset forces every control low
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_o   = 1'b0;
        hold_ex_o = 1'b0;
        bubble_o  = 1'b0;
        flush_o   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch) begin
                    flush_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
                    state_d  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (ex_busy) begin
                    stall_o   = 1'b1;
                    hold_ex_o = 1'b1;
                    state_d   = ST_BUSY;
                end else if (load_use) begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    state_d  = ST_LDSTALL;
                end
            end
            ST_BUSY: begin
                if (ex_busy) begin
                    stall_o   = 1'b1;
                    hold_ex_o = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LDSTALL: begin
                state_d = ST_RUN;
            end
            ST_FLUSH: begin
                flush_o  = 1'b1;
                bubble_o = 1'b1;
                if (branch) begin
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q <= CNT_W'(1)) ? ST_RUN : ST_FLUSH;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            stall_o   = 1'b0;
            hold_ex_o = 1'b0;
            bubble_o  = 1'b0;
            flush_o   = 1'b0;
        end
    end

    // Operand forwarding, EX > MEM > WB > register file; x0 never forwards
    always_comb begin
        ex_fwd_ok  = ex_valid & ex_we & ~ex_is_load;
        m_fwd_ok   = m_q.v & m_q.we;
        w_fwd_ok   = w_q.v & w_q.we;
        m_val      = m_q.ld ? mem_rdata : m_q.data;
        id_rs1_fwd = id_rs1_rdata;
        id_rs2_fwd = id_rs2_rdata;
        if (!rst && (id_rs1 != '0)) begin
            if (ex_fwd_ok && (ex_rd == id_rs1))     id_rs1_fwd = ex_result;
            else if (m_fwd_ok && (m_q.rd == id_rs1)) id_rs1_fwd = m_val;
            else if (w_fwd_ok && (w_q.rd == id_rs1)) id_rs1_fwd = w_q.data;
        end
        if (!rst && (id_rs2 != '0)) begin
            if (ex_fwd_ok && (ex_rd == id_rs2))     id_rs2_fwd = ex_result;
            else if (m_fwd_ok && (m_q.rd == id_rs2)) id_rs2_fwd = m_val;
            else if (w_fwd_ok && (w_q.rd == id_rs2)) id_rs2_fwd = w_q.data;
        end
    end

    // WB writes once per W entry, even when W is held for several cycles
    assign wb_we_o   = ~rst & w_q.v & w_q.we & (w_q.rd != '0) & ~wb_done_q;
    assign wb_rd_o   = w_q.rd;
    assign wb_data_o = w_q.data;

    // The slot behind an inserted bubble is discarded when it reaches M
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            m_q       <= '0;
            w_q       <= '0;
            bubble_q  <= 1'b0;
            wb_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bubble_q  <= bubble_o;
            wb_done_q <= hold_ex_o;
            if (!hold_ex_o) begin
                m_q.v    <= ex_valid & ~bubble_q;
                m_q.rd   <= ex_rd;
                m_q.we   <= ex_we;
                m_q.ld   <= ex_is_load;
                m_q.data <= ex_result;
                w_q      <= m_q;
                if (m_q.ld) w_q.data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ex_id_hazard_fwd.sv
// Self-checking bench for ex_id_hazard_fwd: directed scenarios followed by random traffic
// compared against a queue-based pipeline model.
module tb_ex_id_hazard_fwd;

    localparam int unsigned F = 2;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic [31:0] id_rs1_rdata, id_rs2_rdata;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_we, ex_is_load, ex_busy, ex_branch_taken;
    logic [31:0] ex_result, mem_rdata;
    logic [31:0] id_rs1_fwd, id_rs2_fwd;
    logic        stall_o, hold_ex_o, bubble_o, flush_o, wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    ex_id_hazard_fwd #(.FLUSH_CYCLES(F), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_rdata(id_rs1_rdata), .id_rs2_rdata(id_rs2_rdata),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_result(ex_result), .ex_busy(ex_busy), .ex_branch_taken(ex_branch_taken),
        .mem_rdata(mem_rdata),
        .id_rs1_fwd(id_rs1_fwd), .id_rs2_fwd(id_rs2_fwd),
        .stall_o(stall_o), .hold_ex_o(hold_ex_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        bit          we;
        bit          ld;
        logic [31:0] data;
    } rec_t;

    // Model: retired EX slots, newest first (entry 0 = MEM, entry 1 = WB)
    rec_t hist[$];
    int   flush_left;
    bit   in_busy, after_ld, wrote, prev_bubble;
    bit   e_stall, e_hold, e_bubble, e_flush, e_wb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit lu_now();
        return id_valid && ex_valid && ex_is_load && ex_we && (ex_rd != 0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    function automatic bit br_now();
        return ex_valid && ex_branch_taken && !ex_busy;
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] rdata);
        if (rst || rs == 0) return rdata;
        if (ex_valid && ex_we && !ex_is_load && ex_rd == rs) return ex_result;
        if (hist.size() > 0 && hist[0].v && hist[0].we && hist[0].rd == rs)
            return hist[0].ld ? mem_rdata : hist[0].data;
        if (hist.size() > 1 && hist[1].v && hist[1].we && hist[1].rd == rs) return hist[1].data;
        return rdata;
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rs1_rdata = 32'h0; id_rs2_rdata = 32'h0;
        ex_valid = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_result = 32'h0;
        ex_busy = 0; ex_branch_taken = 0; mem_rdata = 32'h0;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic [31:0] res, input bit ld);
        ex_valid = 1; ex_rd = rd; ex_we = 1; ex_is_load = ld; ex_result = res;
    endtask

    // Compute expectations from the model and compare all outputs
    task automatic settle();
        #1;
        e_stall = 0; e_hold = 0; e_bubble = 0; e_flush = 0;
        if (rst) begin
        end else if (flush_left > 0) begin
            e_flush = 1; e_bubble = 1;
        end else if (in_busy) begin
            e_stall = ex_busy; e_hold = ex_busy;
        end else if (after_ld) begin
        end else if (br_now()) begin
            e_flush = 1; e_bubble = 1;
        end else if (ex_busy) begin
            e_stall = 1; e_hold = 1;
        end else if (lu_now()) begin
            e_stall = 1; e_bubble = 1;
        end
        e_wb = !rst && hist.size() > 1 && hist[1].v && hist[1].we && hist[1].rd != 0 && !wrote;
        chk1("stall", stall_o, e_stall);
        chk1("hold", hold_ex_o, e_hold);
        chk1("bubble", bubble_o, e_bubble);
        chk1("flush", flush_o, e_flush);
        chk1("wb_we", wb_we_o, e_wb);
        if (e_wb) begin
            chk("wb_rd", 32'(wb_rd_o), 32'(hist[1].rd));
            chk("wb_data", wb_data_o, hist[1].data);
        end
        chk("fwd1", id_rs1_fwd, exp_fwd(id_rs1, id_rs1_rdata));
        chk("fwd2", id_rs2_fwd, exp_fwd(id_rs2, id_rs2_rdata));
    endtask

    // Clock edge: move the model forward using the inputs held across the edge
    task automatic advance();
        rec_t nr;
        bit   br;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            flush_left = 0; in_busy = 0; after_ld = 0; wrote = 0; prev_bubble = 0;
        end else begin
            br = br_now();
            if (flush_left > 0)  flush_left = br ? int'(F) - 1 : flush_left - 1;
            else if (in_busy)    in_busy = ex_busy;
            else if (after_ld)   after_ld = 0;
            else if (br)         flush_left = int'(F) - 1;
            else if (ex_busy)    in_busy = 1;
            else if (lu_now())   after_ld = 1;
            if (!e_hold) begin
                if (hist.size() > 0 && hist[0].ld) hist[0].data = mem_rdata;
                nr.v = ex_valid && !prev_bubble;
                nr.rd = ex_rd; nr.we = ex_we; nr.ld = ex_is_load; nr.data = ex_result;
                hist.push_front(nr);
                if (hist.size() > 2) void'(hist.pop_back());
            end
            wrote = e_hold;
            prev_bubble = e_bubble;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        hist.delete();
        flush_left = 0; in_busy = 0; after_ld = 0; wrote = 0; prev_bubble = 0;

        // Reset: controls low, operands pass through
        rst = 1;
        id_rs1 = 5; id_rs1_rdata = 32'hCAFE;
        set_ex(5'd5, 32'h99, 0);
        settle();
        chk("rst_fwd1", id_rs1_fwd, 32'hCAFE);
        chk1("rst_wb_we", wb_we_o, 1'b0);
        advance();
        settle(); advance();
        rst = 0;
        clear_inputs();

        // Back-to-back dependency through EX, MEM and WB
        set_ex(5'd5, 32'h11, 0);
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs1_rdata = 32'h999;
        settle(); chk("tp1_ex", id_rs1_fwd, 32'h11); advance();
        ex_valid = 0; ex_rd = 9; mem_rdata = 32'h55;
        settle(); chk("tp1_mem", id_rs1_fwd, 32'h11); advance();
        settle();
        chk("tp1_wb", id_rs1_fwd, 32'h11);
        chk1("tp1_wb_we", wb_we_o, 1'b1);
        chk("tp1_wb_rd", 32'(wb_rd_o), 32'd5);
        advance();
        clear_inputs();

        // Load-use: one stall+bubble, then forward from mem_rdata
        set_ex(5'd7, 32'h100, 1);
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1; id_rs2_rdata = 32'h222;
        settle(); chk1("tp2_stall", stall_o, 1'b1); chk1("tp2_bubble", bubble_o, 1'b1); advance();
        ex_valid = 0; ex_is_load = 0; ex_we = 0; mem_rdata = 32'hABCD;
        settle(); chk("tp2_fwd", id_rs2_fwd, 32'hABCD); chk1("tp2_nostall", stall_o, 1'b0); advance();
        mem_rdata = 32'h0;
        settle(); chk("tp2_wb_data", wb_data_o, 32'hABCD); chk("tp2_wb_fwd", id_rs2_fwd, 32'hABCD); advance();
        clear_inputs();

        // Taken branch: flush for F cycles, load-use ignored meanwhile
        ex_valid = 1; ex_branch_taken = 1;
        settle(); chk1("tp3_flush0", flush_o, 1'b1); chk1("tp3_bub0", bubble_o, 1'b1); advance();
        clear_inputs();
        set_ex(5'd7, 32'h200, 1);
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
        settle(); chk1("tp3_flush1", flush_o, 1'b1); chk1("tp3_lu_ign", stall_o, 1'b0); advance();
        clear_inputs();
        settle(); chk1("tp3_flush_end", flush_o, 1'b0); chk1("tp3_bub_end", bubble_o, 1'b0); advance();

        // Multi-cycle EX: hold 4 cycles, single WB pulse
        set_ex(5'd4, 32'h44, 0); settle(); advance();
        set_ex(5'd8, 32'h88, 0); settle(); advance();
        set_ex(5'd9, 32'h77, 0); ex_busy = 1;
        id_valid = 1; id_rs1 = 4; id_rs1_used = 1; id_rs1_rdata = 32'h1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk1("tp4_hold", hold_ex_o, 1'b1);
            chk1("tp4_wb_once", wb_we_o, c == 0);
            chk("tp4_fwd_w", id_rs1_fwd, 32'h44);
            advance();
        end
        ex_busy = 0;
        settle(); chk1("tp4_drop", stall_o, 1'b0); chk1("tp4_drop_wb", wb_we_o, 1'b0); advance();
        clear_inputs();
        settle(); chk("tp4_next_rd", 32'(wb_rd_o), 32'd8); advance();

        // x0 never forwards or writes; EX beats WB
        set_ex(5'd0, 32'h5, 0); settle(); advance();
        set_ex(5'd3, 32'h33, 0); settle(); advance();
        set_ex(5'd0, 32'h6, 0);
        id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs1_rdata = 32'h1234;
        settle(); chk("tp5_x0_fwd", id_rs1_fwd, 32'h1234); chk1("tp5_x0_wb", wb_we_o, 1'b0); advance();
        set_ex(5'd3, 32'h3333, 0); id_rs1 = 3;
        settle(); chk("tp5_prio", id_rs1_fwd, 32'h3333); chk("tp5_wb_rd", 32'(wb_rd_o), 32'd3); advance();
        clear_inputs();

        // Reset in the second flush cycle
        ex_valid = 1; ex_branch_taken = 1; settle(); advance();
        clear_inputs(); rst = 1;
        settle(); chk1("tp6_rst_flush", flush_o, 1'b0); advance();
        rst = 0;
        set_ex(5'd7, 32'h300, 1);
        id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
        settle(); chk1("tp6_flush", flush_o, 1'b0); chk1("tp6_wb", wb_we_o, 1'b0);
        chk1("tp6_run_lu", stall_o, 1'b1); advance();
        clear_inputs(); settle(); advance();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rs1_used = ($urandom_range(0, 3) != 0);
            id_rs2_used = ($urandom_range(0, 1) != 0);
            id_rs1_rdata = 32'($urandom);
            id_rs2_rdata = 32'($urandom);
            ex_valid = ($urandom_range(0, 4) != 0);
            ex_rd = 5'($urandom_range(0, 7));
            ex_we = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_result = 32'($urandom);
            ex_busy = in_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 11) == 0);
            ex_branch_taken = ($urandom_range(0, 11) == 0);
            mem_rdata = 32'($urandom);
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
